// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: steers loads/stores onto a req/ack data bus, extends load data,
// flags misaligned accesses and stalls the pipeline while a bus access is outstanding.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  register_destination_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_signed_in,
    input  logic        jump_in,
    input  logic        branch_in,
    input  logic        pc_control_in,
    input  logic        memory_to_register_in,
    input  logic        reg_write_in,
    output logic [31:0] memory_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  register_destination_out,
    output logic        jump_out,
    output logic        branch_out,
    output logic        pc_control_out,
    output logic        memory_to_register_out,
    output logic        reg_write_out,
    output logic        stall_out,
    output logic        misalign_exc_out,
    output logic        bus_error_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  timeout_cnt_q;
    logic [31:0] load_data_q;

    logic [1:0]  off;
    logic        is_byte, is_half;
    logic        mem_op, misaligned, timeout;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_ext;
    logic [4:0]  ctl_in, ctl_out;

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        unique case (lane)
            2'd0: b = raw[7:0];
            2'd1: b = raw[15:8];
            2'd2: b = raw[23:16];
            2'd3: b = raw[31:24];
        endcase
        h = lane[1] ? raw[31:16] : raw[15:0];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return raw;
        endcase
    endfunction

    assign off        = alu_result_in[1:0];
    assign is_byte    = (mem_size_in == 2'b00);
    assign is_half    = (mem_size_in == 2'b01);
    assign mem_op     = valid_in & (mem_read_in | mem_write_in);
    assign misaligned = (is_half & off[0]) | (!is_byte && !is_half && off != 2'b00);
    assign timeout    = (state_q == StBusy) && !dmem_ack && (timeout_cnt_q == TimeoutLimit);

    // Store lanes: data is replicated so the enabled lanes always carry the right bytes.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = store_data_in;
        if (is_byte) begin
            store_be    = 4'b0001 << off;
            store_wdata = {4{store_data_in[7:0]}};
        end else if (is_half) begin
            store_be    = off[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{store_data_in[15:0]}};
        end
    end

    // EX/MEM is held by the stall, so its size/offset/sign are still valid in DONE.
    assign load_ext = extend_load(load_data_q, mem_size_in, off, mem_signed_in);

    assign ctl_in = {jump_in, branch_in, pc_control_in, memory_to_register_in, reg_write_in};
    assign {jump_out, branch_out, pc_control_out, memory_to_register_out, reg_write_out} = ctl_out;

    assign alu_result_out           = alu_result_in;
    assign register_destination_out = register_destination_in;

    always_comb begin
        stall_out        = 1'b0;
        misalign_exc_out = 1'b0;
        bus_error_out    = 1'b0;
        memory_data_out  = 32'h0;
        ctl_out          = valid_in ? ctl_in : 5'b0;
        case (state_q)
            StIdle: begin
                if (mem_op && misaligned) begin
                    misalign_exc_out = 1'b1;
                    ctl_out[1:0]     = 2'b00;
                end else if (mem_op) begin
                    stall_out = 1'b1;
                    ctl_out   = 5'b0;
                end
            end
            StBusy: begin
                stall_out     = 1'b1;
                ctl_out       = 5'b0;
                bus_error_out = timeout;
            end
            StDone: begin
                if (valid_in && mem_read_in) begin
                    memory_data_out = load_ext;
                end
            end
            default: ;
        endcase
    end

    // Asynchronous reset abandons any outstanding access; a later ack lands in IDLE and is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            timeout_cnt_q <= 8'h0;
            load_data_q   <= 32'h0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0;
            dmem_be       <= 4'h0;
            dmem_wdata    <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_op && !misaligned) begin
                        dmem_req      <= 1'b1;
                        dmem_we       <= mem_write_in & ~mem_read_in;
                        dmem_addr     <= {alu_result_in[31:2], 2'b00};
                        dmem_be       <= mem_read_in ? 4'b1111 : store_be;
                        dmem_wdata    <= store_wdata;
                        timeout_cnt_q <= 8'h0;
                        state_q       <= StBusy;
                    end
                end
                StBusy: begin
                    if (dmem_ack) begin
                        load_data_q   <= mem_read_in ? dmem_rdata : 32'h0;
                        timeout_cnt_q <= 8'h0;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        state_q       <= StDone;
                    end else if (timeout) begin
                        load_data_q   <= 32'h0;
                        timeout_cnt_q <= 8'h0;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        state_q       <= StDone;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: per-transaction reference model with a simple bus responder.
module tb_mem_access_stage;

    localparam int unsigned T = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  register_destination_in;
    logic        mem_read_in, mem_write_in, mem_signed_in;
    logic [1:0]  mem_size_in;
    logic        jump_in, branch_in, pc_control_in, memory_to_register_in, reg_write_in;
    logic [31:0] memory_data_out, alu_result_out;
    logic [4:0]  register_destination_out;
    logic        jump_out, branch_out, pc_control_out, memory_to_register_out, reg_write_out;
    logic        stall_out, misalign_exc_out, bus_error_out;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .register_destination_in(register_destination_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_size_in(mem_size_in),
        .mem_signed_in(mem_signed_in), .jump_in(jump_in), .branch_in(branch_in),
        .pc_control_in(pc_control_in), .memory_to_register_in(memory_to_register_in),
        .reg_write_in(reg_write_in), .memory_data_out(memory_data_out),
        .alu_result_out(alu_result_out), .register_destination_out(register_destination_out),
        .jump_out(jump_out), .branch_out(branch_out), .pc_control_out(pc_control_out),
        .memory_to_register_out(memory_to_register_out), .reg_write_out(reg_write_out),
        .stall_out(stall_out), .misalign_exc_out(misalign_exc_out),
        .bus_error_out(bus_error_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ctl_out();
        return {jump_out, branch_out, pc_control_out, memory_to_register_out, reg_write_out};
    endfunction

    // Reference rules, written with plain arithmetic on byte offsets.
    function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] sz,
                                             input logic [31:0] addr, input logic sgn);
        int unsigned o = addr % 4;
        logic [31:0] v;
        if (sz == 0) begin
            v = (raw >> (8 * o)) & 32'hFF;
            if (sgn && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (raw >> (16 * (o / 2))) & 32'hFFFF;
            if (sgn && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic rd, input logic [1:0] sz,
                                          input logic [31:0] addr);
        int unsigned o = addr % 4;
        if (rd || sz >= 2) return 4'd15;
        if (sz == 0) return 4'(1 << o);
        return (o >= 2) ? 4'd12 : 4'd3;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 0) return (sd % 256) * 32'h01010101;
        if (sz == 1) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 1) return (addr % 2) != 0;
        if (sz >= 2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    // Runs one instruction from its IDLE cycle to completion. Entered and left #1 after posedge.
    // d = BUSY cycle index on which ack arrives (>= T means never).
    task automatic do_txn(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] rdst, input logic [4:0] ctl, input int d,
                          input logic [31:0] rdata);
        logic mop, mis, got_ack, to;
        valid_in = v; mem_read_in = rd; mem_write_in = wr; mem_size_in = sz;
        mem_signed_in = sgn; alu_result_in = addr; store_data_in = sd;
        register_destination_in = rdst;
        {jump_in, branch_in, pc_control_in, memory_to_register_in, reg_write_in} = ctl;
        mop = v & (rd | wr);
        mis = ref_misaligned(sz, addr);
        dmem_ack = (!mop || mis) ? 1'($urandom % 2) : 1'b0;
        dmem_rdata = $urandom;
        @(negedge clk);
        check_eq("alu_pass", alu_result_out, addr);
        check_eq("rd_pass", 32'(register_destination_out), 32'(rdst));
        check_eq("idle_req", 32'(dmem_req), 32'd0);
        check_eq("idle_mdata", memory_data_out, 32'd0);
        if (!mop || mis) begin
            check_eq("idle_ctl", 32'(ctl_out()), 32'(!v ? 5'b0 : (mop ? (ctl & 5'b11100) : ctl)));
            check_eq("idle_stall", 32'(stall_out), 32'd0);
            check_eq("misalign", 32'(misalign_exc_out), 32'(mop));
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            return;
        end
        check_eq("idle_stall", 32'(stall_out), 32'd1);
        check_eq("idle_ctl", 32'(ctl_out()), 32'd0);
        check_eq("misalign", 32'(misalign_exc_out), 32'd0);
        @(posedge clk); #1;
        got_ack = 1'b0;
        for (int k = 0; k < int'(T); k++) begin
            got_ack = (k == d);
            to = (k == int'(T) - 1) && !got_ack;
            dmem_ack = got_ack;
            dmem_rdata = got_ack ? rdata : $urandom;
            @(negedge clk);
            check_eq("busy_req", 32'(dmem_req), 32'd1);
            check_eq("busy_addr", dmem_addr, addr & 32'hFFFFFFFC);
            check_eq("busy_be", 32'(dmem_be), 32'(ref_be(rd, sz, addr)));
            check_eq("busy_we", 32'(dmem_we), 32'(wr & !rd));
            if (!rd) check_eq("busy_wdata", dmem_wdata, ref_wdata(sz, sd));
            check_eq("busy_stall", 32'(stall_out), 32'd1);
            check_eq("busy_ctl", 32'(ctl_out()), 32'd0);
            check_eq("bus_error", 32'(bus_error_out), 32'(to));
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (got_ack || to) break;
        end
        // Stray ack in DONE must be ignored.
        dmem_ack = 1'($urandom % 2);
        dmem_rdata = $urandom;
        @(negedge clk);
        check_eq("done_stall", 32'(stall_out), 32'd0);
        check_eq("done_req", 32'(dmem_req), 32'd0);
        check_eq("done_err", 32'(bus_error_out), 32'd0);
        check_eq("done_ctl", 32'(ctl_out()), 32'(ctl));
        check_eq("done_mdata", memory_data_out,
                 (rd && got_ack) ? ref_load(rdata, sz, addr, sgn) : 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] addr;
        int          kind;
        rst = 1'b1; valid_in = 0; alu_result_in = 0; store_data_in = 0;
        register_destination_in = 0; mem_read_in = 0; mem_write_in = 0; mem_size_in = 0;
        mem_signed_in = 0; jump_in = 0; branch_in = 0; pc_control_in = 0;
        memory_to_register_in = 0; reg_write_in = 0; dmem_ack = 0; dmem_rdata = 0;
        #23;
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_we", 32'(dmem_we), 32'd0);
        check_eq("rst_addr", dmem_addr, 32'd0);
        check_eq("rst_be", 32'(dmem_be), 32'd0);
        check_eq("rst_wdata", dmem_wdata, 32'd0);
        check_eq("rst_stall", 32'(stall_out), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the block's intended use.
        do_txn(1, 1, 0, 2'b10, 0, 32'h100, 0, 5'd8, 5'b00011, 3, 32'hDEADBEEF);
        do_txn(1, 1, 0, 2'b00, 1, 32'h103, 0, 5'd9, 5'b00011, 1, 32'h80123456);
        do_txn(1, 1, 0, 2'b00, 0, 32'h103, 0, 5'd9, 5'b00011, 0, 32'h80123456);
        do_txn(1, 0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 5'd0, 5'b00000, 2, 0);
        do_txn(1, 1, 0, 2'b10, 0, 32'h101, 0, 5'd4, 5'b00011, 0, 0);
        do_txn(1, 1, 0, 2'b10, 1, 32'h200, 0, 5'd5, 5'b00011, 99, 32'hFFFFFFFF);
        do_txn(1, 1, 0, 2'b01, 1, 32'h202, 0, 5'd6, 5'b00011, int'(T) - 1, 32'h8001_7FFF);

        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom % 8);
            sz = 2'($urandom % 4);
            addr = $urandom;
            if (kind >= 3 && kind <= 6) begin
                if (sz == 1) addr[0] = 1'b0;
                else if (sz >= 2) addr[1:0] = 2'b00;
            end
            do_txn(kind != 0, kind == 0 ? 1'($urandom % 2) : (kind == 3 || kind == 4 || kind == 7),
                   kind == 5 || kind == 6, sz, 1'($urandom % 2), addr, $urandom,
                   5'($urandom), 5'($urandom), int'($urandom % (T + 2)), $urandom);
        end

        // Reset mid-BUSY, then a late ack while a plain ALU op passes through.
        valid_in = 1; mem_read_in = 1; mem_write_in = 0; mem_size_in = 2'b10;
        alu_result_in = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_rst_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_busy_req", 32'(dmem_req), 32'd0);
        mem_read_in = 0; alu_result_in = 32'h55; register_destination_in = 5'd3;
        {jump_in, branch_in, pc_control_in, memory_to_register_in, reg_write_in} = 5'b00001;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check_eq("add_stall", 32'(stall_out), 32'd0);
        check_eq("add_ctl", 32'(ctl_out()), 32'd1);
        check_eq("add_rd", 32'(register_destination_out), 32'd3);
        check_eq("late_ack_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check_eq("late_ack_stall", 32'(stall_out), 32'd0);
        check_eq("late_ack_mdata", memory_data_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
